// File: rtl/pattern_bit_serializer_if.sv
// Handshake bundle for pattern_bit_serializer.
//   data_in/data_valid/data_ready : parallel word push with backpressure
//   hold                          : downstream stall request
//   d_o/valid_o/word_done         : registered serial stream and end-of-word pulse
//   busy/ovf_err                  : activity and sticky overflow status
// master drives words and hold; slave is the serializer.
interface pattern_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             hold;
  logic             d_o;
  logic             valid_o;
  logic             word_done;
  logic             busy;
  logic             ovf_err;

  modport master (
    output data_in, data_valid, hold,
    input  data_ready, d_o, valid_o, word_done, busy, ovf_err
  );

  modport slave (
    input  data_in, data_valid, hold,
    output data_ready, d_o, valid_o, word_done, busy, ovf_err
  );
endinterface

// File: rtl/pattern_bit_serializer.sv
// pattern_bit_serializer: buffers WIDTH-bit words in a DEPTH-entry FIFO and
// shifts them out one bit per cycle, MSB or LSB first.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : pattern_bit_serializer_if slave modport (word input, hold, serial
//         output, word_done pulse, busy and sticky ovf_err status)
module pattern_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  pattern_bit_serializer_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [IW-1:0]    idx;
  logic             d_q, valid_q, done_q, ovf_q;

  logic             ready, push, pop;
  logic [WIDTH-1:0] head;
  logic             head_bit, sreg_bit;
  logic [WIDTH-1:0] head_rest, sreg_rest;

  assign ready = (count < CW'(DEPTH));
  assign push  = bus.data_valid && ready;
  assign head  = mem[rd_ptr];
  // The final bit sends the FSM straight back to IDLE, so IDLE is the only
  // place a word is popped; it still gives zero-gap back-to-back output.
  assign pop   = (state == IDLE) && (count != '0) && !bus.hold;

  always_comb begin
    head_bit  = 1'b0;
    sreg_bit  = 1'b0;
    head_rest = '0;
    sreg_rest = '0;
    if (MSB_FIRST != 0) begin
      head_bit  = head[WIDTH-1];
      sreg_bit  = sreg[WIDTH-1];
      head_rest = {head[WIDTH-2:0], 1'b0};
      sreg_rest = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      head_bit  = head[0];
      sreg_bit  = sreg[0];
      head_rest = {1'b0, head[WIDTH-1:1]};
      sreg_rest = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // Storage array carries no reset; only pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.data_valid && !ready) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      idx     <= '0;
      d_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            d_q     <= head_bit;
            sreg    <= head_rest;
            idx     <= IW'(1);
            valid_q <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!bus.hold) begin
            d_q     <= sreg_bit;
            sreg    <= sreg_rest;
            valid_q <= 1'b1;
            if (idx == IW'(WIDTH - 1)) begin
              done_q <= 1'b1;
              idx    <= '0;
              state  <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_ready = ready;
  assign bus.d_o        = d_q;
  assign bus.valid_o    = valid_q;
  assign bus.word_done  = done_q;
  assign bus.busy       = (count != '0) || (state == SHIFT);
  assign bus.ovf_err    = ovf_q;

endmodule
